alu_fault_injector: RTL and testbench

- Fault-injection source for the redundant ALU bank: drives faults into the N replica result buses, ahead of the majority voter and its per-bit disable switches.
- Sits between the replica outputs and the voter.
- Accepts fault commands over a valid/ready interface and applies stuck-at-0, stuck-at-1 or bit-flip faults after a programmed delay, for a programmed duration or permanently.
- Lets the team exercise the voter and self-disable logic from a bench or an on-chip test controller.

---
 rtl/alu_fault_injector.sv | 181 ++++++++++++++++++
 tb/tb_alu_fault_injector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fault_injector.sv
// Fault injector on replica result buses: faults applied 2+delay cycles after accept; cmd_ready low while a command is armed/active.
// Optional FI_LFSR_EN adds cmd_rand: bit index drawn from a 16-bit LFSR instead of cmd_bit.
module alu_fault_injector #(
  parameter int NREP  = 5,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREP*WIDTH-1:0] res_in,
  output logic [NREP*WIDTH-1:0] res_out,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_replica,
  input  logic [4:0]            cmd_bit,
  input  logic [1:0]            cmd_type,
  input  logic [15:0]           cmd_delay,
  input  logic [15:0]           cmd_duration,
`ifdef FI_LFSR_EN
  input  logic                  cmd_rand,
`endif
  input  logic                  clear,
  output logic                  active,
  output logic                  err,
  output logic [7:0]            inj_count
);

  localparam int NB = NREP * WIDTH;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]    r_state;
  logic [15:0]   r_cnt;
  logic [15:0]   r_dur;
  logic [2:0]    r_rep;
  logic [4:0]    r_bit;
  logic [1:0]    r_type;
  logic [NB-1:0] r_sand, r_sor, r_sxor;
  logic [NB-1:0] r_tand, r_tor, r_txor;
  logic          r_active;
  logic          r_err;
  logic [7:0]    r_inj;

  logic [4:0]    w_bit_sel;
  logic          w_rep_bad, w_bit_bad, w_bad;
  logic          w_perm, w_tr_on;
  logic [NB-1:0] w_hit, w_m0, w_m1, w_mx;
  logic [NB-1:0] w_and, w_or, w_xor;

`ifdef FI_LFSR_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_lfsr <= 16'hACE1;
    else          r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_bit_sel = cmd_rand ? r_lfsr[4:0] : cmd_bit;
`else
  assign w_bit_sel = cmd_bit;
`endif

  // Range checks only exist where the field can actually exceed the parameter.
  generate
    if (NREP < 8) begin : g_rep_chk
      assign w_rep_bad = (cmd_replica >= 3'(NREP));
    end else begin : g_rep_nochk
      assign w_rep_bad = 1'b0;
    end
    if (WIDTH < 32) begin : g_bit_chk
      assign w_bit_bad = (w_bit_sel >= 5'(WIDTH));
    end else begin : g_bit_nochk
      assign w_bit_bad = 1'b0;
    end
  endgenerate

  assign w_bad     = w_rep_bad | w_bit_bad | (cmd_type == 2'b11);
  assign cmd_ready = (r_state == S_IDLE) & ~clear;
  assign w_perm    = (r_dur == 16'd0);
  assign w_tr_on   = (r_state == S_ACTIVE) & ~w_perm;

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < NREP; k++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (r_rep == 3'(k) && r_bit == 5'(b)) w_hit[k*WIDTH + b] = 1'b1;
      end
    end
  end

  assign w_m0 = (r_type == 2'b00) ? w_hit : '0;
  assign w_m1 = (r_type == 2'b01) ? w_hit : '0;
  assign w_mx = (r_type == 2'b10) ? w_hit : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dur    <= '0;
      r_rep    <= '0;
      r_bit    <= '0;
      r_type   <= '0;
      r_sand   <= '1;
      r_sor    <= '0;
      r_sxor   <= '0;
      r_tand   <= '1;
      r_tor    <= '0;
      r_txor   <= '0;
      r_active <= 1'b0;
      r_err    <= 1'b0;
      r_inj    <= '0;
    end else begin
      r_err <= 1'b0;
      if (clear) begin
        r_state  <= S_IDLE;
        r_sand   <= '1;
        r_sor    <= '0;
        r_sxor   <= '0;
        r_tand   <= '1;
        r_tor    <= '0;
        r_txor   <= '0;
        r_active <= 1'b0;
      end else begin
        // Transient masks are registered, so they trail ACTIVE entry by one cycle.
        r_tand   <= w_tr_on ? ~w_m0 : '1;
        r_tor    <= w_tr_on ? w_m1  : '0;
        r_txor   <= w_tr_on ? w_mx  : '0;
        r_active <= w_tr_on;
        case (r_state)
          S_IDLE: begin
            if (cmd_valid) begin
              if (w_bad) begin
                r_err <= 1'b1;
              end else begin
                r_rep   <= cmd_replica;
                r_bit   <= w_bit_sel;
                r_type  <= cmd_type;
                r_dur   <= cmd_duration;
                r_cnt   <= cmd_delay;
                r_state <= S_ARMED;
              end
            end
          end
          S_ARMED: begin
            if (r_cnt == 16'd0) begin
              r_state <= S_ACTIVE;
              r_cnt   <= r_dur;
              if (r_inj != 8'hFF) r_inj <= r_inj + 8'd1;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          S_ACTIVE: begin
            if (w_perm) begin
              r_sand  <= r_sand & ~w_m0;
              r_sor   <= r_sor | w_m1;
              r_sxor  <= r_sxor | w_mx;
              r_state <= S_IDLE;
            end else if (r_cnt == 16'd1) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 16'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Flip bits from sticky and transient sources OR together rather than cancel.
  assign w_and   = r_sand & r_tand;
  assign w_or    = r_sor | r_tor;
  assign w_xor   = r_sxor | r_txor;
  assign res_out = ((res_in & w_and) | w_or) ^ w_xor;

  assign active    = r_active;
  assign err       = r_err;
  assign inj_count = r_inj;

endmodule

// File: tb/tb_alu_fault_injector.sv
// Randomised and directed bench for alu_fault_injector against a time-based fault model.
module tb_alu_fault_injector;
  localparam int NREP  = 5;
  localparam int WIDTH = 32;
  localparam int NB    = NREP * WIDTH;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] res_in, res_out;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_replica;
  logic [4:0]    cmd_bit;
  logic [1:0]    cmd_type;
  logic [15:0]   cmd_delay, cmd_duration;
  logic          clear, active, err;
  logic [7:0]    inj_count;

  alu_fault_injector #(.NREP(NREP), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .res_in(res_in), .res_out(res_out),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_replica(cmd_replica),
    .cmd_bit(cmd_bit), .cmd_type(cmd_type), .cmd_delay(cmd_delay),
    .cmd_duration(cmd_duration), .clear(clear), .active(active), .err(err),
    .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: sticky fault bit sets per replica plus one scheduled transient, keyed on edge numbers.
  logic [31:0] s0 [NREP];
  logic [31:0] s1 [NREP];
  logic [31:0] sf [NREP];
  int  n;
  bit  busy, t_live, m_perm, m_err;
  int  m_rep, m_bit, m_type, m_dur, m_inj;
  int  e_cnt, e_start, e_ready;

  task automatic chk(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NREP; k++) begin
      s0[k] = '0; s1[k] = '0; sf[k] = '0;
    end
    busy = 0; t_live = 0; m_err = 0; m_inj = 0; m_perm = 0;
  endtask

  function automatic bit tr_vis();
    return t_live && (n >= e_start) && (n < e_start + m_dur);
  endfunction

  function automatic logic [WIDTH-1:0] exp_rep(input int k, input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] r;
    bit z, o, f;
    for (int b = 0; b < WIDTH; b++) begin
      z = s0[k][b]; o = s1[k][b]; f = sf[k][b];
      if (tr_vis() && m_rep == k && m_bit == b) begin
        if (m_type == 0) z = 1;
        else if (m_type == 1) o = 1;
        else f = 1;
      end
      r[b] = (o ? 1'b1 : (z ? 1'b0 : din[b])) ^ f;
    end
    return r;
  endfunction

  task automatic model_edge();
    n++;
    m_err = 0;
    if (!reset_n) return;
    if (clear) begin
      for (int k = 0; k < NREP; k++) begin
        s0[k] = '0; s1[k] = '0; sf[k] = '0;
      end
      busy = 0; t_live = 0;
    end else if (!busy) begin
      if (cmd_valid) begin
        if (int'(cmd_replica) >= NREP || cmd_type == 2'b11) begin
          m_err = 1;
        end else begin
          busy    = 1;
          m_rep   = int'(cmd_replica);
          m_bit   = int'(cmd_bit);
          m_type  = int'(cmd_type);
          m_dur   = int'(cmd_duration);
          m_perm  = (cmd_duration == 0);
          t_live  = !m_perm;
          e_cnt   = n + 1 + int'(cmd_delay);
          e_start = n + 2 + int'(cmd_delay);
          e_ready = m_perm ? e_start : n + 1 + int'(cmd_delay) + m_dur;
        end
      end
    end else begin
      if (n == e_cnt && m_inj < 255) m_inj++;
      if (m_perm && n == e_start) begin
        if (m_type == 0) s0[m_rep][m_bit] = 1'b1;
        else if (m_type == 1) s1[m_rep][m_bit] = 1'b1;
        else sf[m_rep][m_bit] = 1'b1;
      end
      if (n == e_ready) busy = 0;
    end
  endtask

  task automatic check_all();
    logic [NB-1:0] e;
    for (int k = 0; k < NREP; k++) e[k*WIDTH +: WIDTH] = exp_rep(k, res_in[k*WIDTH +: WIDTH]);
    chk("res_out", res_out, e);
    chk("cmd_ready", NB'(cmd_ready), NB'(!busy && !clear));
    chk("active", NB'(active), NB'(tr_vis()));
    chk("err", NB'(err), NB'(m_err));
    chk("inj_count", NB'(inj_count), NB'(m_inj));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_cmd(input int rep, input int bitn, input int typ, input int dly, input int dur);
    cmd_valid    = 1'b1;
    cmd_replica  = 3'(rep);
    cmd_bit      = 5'(bitn);
    cmd_type     = 2'(typ);
    cmd_delay    = 16'(dly);
    cmd_duration = 16'(dur);
  endtask

  localparam logic [31:0] BASE = 32'h1234_5678;

  initial begin
    n = 0;
    model_reset();
    reset_n = 1'b0; clear = 1'b0; cmd_valid = 1'b0;
    cmd_replica = '0; cmd_bit = '0; cmd_type = '0; cmd_delay = '0; cmd_duration = '0;
    res_in = {NREP{BASE}};

    // Reset state
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_out", res_out, {NREP{BASE}});
    chk("rst_ready", NB'(cmd_ready), NB'(1));
    chk("rst_inj", NB'(inj_count), NB'(0));

    // Transient flip on replica 2 bit 0, delay 3, duration 4
    set_cmd(2, 0, 2, 3, 4);
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("flip_r2", NB'(res_out[2*WIDTH +: WIDTH]), NB'((i >= 5 && i <= 8) ? 32'h1234_5679 : BASE));
      chk("flip_act", NB'(active), NB'(i >= 5 && i <= 8));
    end
    chk("flip_inj", NB'(inj_count), NB'(1));

    // Permanent stuck-1 on replica 0 bit 31, then clear
    set_cmd(0, 31, 1, 0, 0);
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    chk("perm_r0", NB'(res_out[WIDTH-1:0]), NB'(32'h9234_5678));
    chk("perm_act", NB'(active), NB'(0));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("clr_r0", NB'(res_out[WIDTH-1:0]), NB'(BASE));

    // Rejected commands: bad replica, reserved type
    for (int j = 0; j < 2; j++) begin
      if (j == 0) set_cmd(5, 3, 0, 0, 2);
      else        set_cmd(1, 3, 3, 0, 2);
      tick();
      cmd_valid = 1'b0;
      chk("rej_err", NB'(err), NB'(1));
      chk("rej_out", res_out, {NREP{BASE}});
      tick();
      chk("rej_err_drop", NB'(err), NB'(0));
      chk("rej_ready", NB'(cmd_ready), NB'(1));
    end

    // Reset in the middle of a long delay
    set_cmd(3, 7, 1, 100, 5);
    tick();
    cmd_valid = 1'b0;
    repeat (50) tick();
    chk("armed_ready", NB'(cmd_ready), NB'(0));
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("amid_out", res_out, res_in);
    chk("amid_inj", NB'(inj_count), NB'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("arel_ready", NB'(cmd_ready), NB'(1));
    chk("arel_inj", NB'(inj_count), NB'(0));

    // clear wins over cmd_valid
    set_cmd(1, 4, 0, 0, 2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cmd_valid = 1'b0;
    tick();
    chk("clrv_ready", NB'(cmd_ready), NB'(1));
    chk("clrv_inj", NB'(inj_count), NB'(0));

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NREP; k++) res_in[k*WIDTH +: WIDTH] = $urandom;
      set_cmd($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 3),
              $urandom_range(0, 5), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6));
      cmd_valid = ($urandom_range(0, 2) == 0);
      clear     = ($urandom_range(0, 49) == 0);
      tick();
    end
    clear = 1'b0;

    // Saturation of the activation counter
    for (int c = 0; c < 1000; c++) begin
      res_in = {NREP{BASE}};
      set_cmd($urandom_range(0, NREP - 1), $urandom_range(0, 31), 2, 0, 1);
      tick();
    end
    cmd_valid = 1'b0;
    repeat (4) tick();
    chk("sat_inj", NB'(inj_count), NB'(255));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
